doodler_physics: RTL

Per-frame motion engine for the player sprite in the Doodle Jump design. It sits between the VGA sync/frame-tick source and the sprite drawing and platform-scroll logic. Once per frame it applies gravity, horizontal keyboard steering with screen wrap-around, platform bounce and camera-scroll requests, and it tracks the IDLE/PLAY/DEAD game state.

---
 rtl/doodler_physics_if.sv | 24 ++
 rtl/doodler_physics.sv | 127 ++++++++++++
 2 files changed

// File: rtl/doodler_physics_if.sv
// Frame-tick inputs and sprite-state outputs of the doodler motion engine.
// The master drives tick/keyboard/collision; the slave is the physics block.
interface doodler_physics_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       plat_hit;
    logic [9:0] DoodleX;
    logic [9:0] DoodleY;
    logic [5:0] vel_y;
    logic [5:0] scroll_amt;
    logic       scroll_valid;
    logic       game_over;
    logic       update_done;

    modport master (
        output frame_clk, keycode, plat_hit,
        input  DoodleX, DoodleY, vel_y, scroll_amt, scroll_valid, game_over, update_done
    );

    modport slave (
        input  frame_clk, keycode, plat_hit,
        output DoodleX, DoodleY, vel_y, scroll_amt, scroll_valid, game_over, update_done
    );
endinterface

// File: rtl/doodler_physics.sv
// Per-frame player motion: gravity, steering with wrap, platform bounce,
// camera-scroll requests and the IDLE/PLAY/DEAD game state.
module doodler_physics (
    input  logic               Clk,
    input  logic               Reset_n,
    doodler_physics_if.slave   bus
);
    localparam logic [9:0]        XMax       = 10'd639;
    localparam logic [9:0]        XStep      = 10'd2;
    localparam logic [9:0]        StartX     = 10'd320;
    localparam logic [9:0]        StartY     = 10'd400;
    localparam logic signed [11:0] YFloor    = 12'sd471;
    localparam logic signed [11:0] ScrollLine = 12'sd120;
    localparam logic signed [5:0] Gravity    = 6'sd1;
    localparam logic signed [5:0] JumpVel    = -6'sd12;
    localparam logic signed [5:0] VMax       = 6'sd12;
    localparam logic [7:0]        KeyLeft    = 8'h04;
    localparam logic [7:0]        KeyRight   = 8'h07;
    localparam logic [7:0]        KeyStart   = 8'h2C;

    typedef enum logic [1:0] {StIdle, StPlay, StDead} state_e;

    state_e            state_q, state_d;
    logic              frame_q;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [5:0] vy_q, vy_d;
    logic [5:0]        scroll_amt_q, scroll_amt_d;
    logic              scroll_valid_q, scroll_valid_d;
    logic              done_q, done_d;

    logic              tick;
    logic signed [5:0] vy_grav;
    logic signed [5:0] vy_nx;
    logic signed [11:0] y_nx;
    logic [9:0]        x_nx;

    assign tick = bus.frame_clk & ~frame_q;

    // Candidate motion for a PLAY tick; bounce only counts while not rising.
    always_comb begin
        vy_grav = (vy_q >= VMax) ? VMax : vy_q + Gravity;
        vy_nx   = (bus.plat_hit && !vy_q[5]) ? JumpVel : vy_grav;
        y_nx    = {2'b00, y_q} + {{6{vy_nx[5]}}, vy_nx};
        unique case (bus.keycode)
            KeyLeft:  x_nx = (x_q < XStep) ? XMax : x_q - XStep;
            KeyRight: x_nx = (x_q > XMax - XStep) ? 10'd0 : x_q + XStep;
            default:  x_nx = x_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        vy_d           = vy_q;
        scroll_amt_d   = scroll_amt_q;
        scroll_valid_d = 1'b0;
        // Every tick is treated as a position update, including held IDLE/DEAD frames.
        done_d         = tick;
        unique case (state_q)
            StIdle: begin
                if (tick && bus.keycode == KeyStart) begin
                    state_d = StPlay;
                    vy_d    = JumpVel;
                end
            end
            StPlay: begin
                if (tick) begin
                    x_d = x_nx;
                    if (y_nx > YFloor) begin
                        y_d     = YFloor[9:0];
                        vy_d    = 6'sd0;
                        state_d = StDead;
                    end else if (y_nx < ScrollLine) begin
                        y_d            = ScrollLine[9:0];
                        vy_d           = vy_nx;
                        scroll_amt_d   = 6'(ScrollLine - y_nx);
                        scroll_valid_d = 1'b1;
                    end else begin
                        y_d  = y_nx[9:0];
                        vy_d = vy_nx;
                    end
                end
            end
            StDead: begin
                if (tick && bus.keycode == KeyStart) begin
                    state_d = StIdle;
                    x_d     = StartX;
                    y_d     = StartY;
                    vy_d    = 6'sd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= StIdle;
            frame_q        <= 1'b0;
            x_q            <= StartX;
            y_q            <= StartY;
            vy_q           <= 6'sd0;
            scroll_amt_q   <= 6'd0;
            scroll_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_q        <= bus.frame_clk;
            x_q            <= x_d;
            y_q            <= y_d;
            vy_q           <= vy_d;
            scroll_amt_q   <= scroll_amt_d;
            scroll_valid_q <= scroll_valid_d;
            done_q         <= done_d;
        end
    end

    assign bus.DoodleX      = x_q;
    assign bus.DoodleY      = y_q;
    assign bus.vel_y        = vy_q;
    assign bus.scroll_amt   = scroll_amt_q;
    assign bus.scroll_valid = scroll_valid_q;
    assign bus.game_over    = (state_q == StDead);
    assign bus.update_done  = done_q;
endmodule
